// File: rtl/ball_motion_if.sv
// Ball block bus: per-tick control and geometry in, ball position and scoring out.
// The controller side (master) drives geometry and strobes; ball_motion is the slave.
interface ball_motion_if;
    logic       tick;
    logic       serve;
    logic [5:0] wall_width;
    logic [5:0] ball_width;
    logic [5:0] paddle_width;
    logic [8:0] paddle_length;
    logic [8:0] left_paddle_y;
    logic [8:0] right_paddle_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       ball_direction;
    logic       score_left;
    logic       score_right;
    logic [1:0] state;

    modport master (
        output tick, serve, wall_width, ball_width, paddle_width,
               paddle_length, left_paddle_y, right_paddle_y,
        input  ball_x, ball_y, ball_direction, score_left, score_right, state
    );

    modport slave (
        input  tick, serve, wall_width, ball_width, paddle_width,
               paddle_length, left_paddle_y, right_paddle_y,
        output ball_x, ball_y, ball_direction, score_left, score_right, state
    );
endinterface

// File: rtl/ball_motion.sv
// Ball owner for the pong pipeline: serve/play/score sequencing, wall and paddle
// bounces, miss detection with one-clock score pulses. All outputs registered.
module ball_motion #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned DX         = 4,
    parameter int unsigned DY         = 2,
    parameter int unsigned HOLD_TICKS = 60
) (
    input  logic          clk,
    input  logic          reset,
    ball_motion_if.slave  bus
);
    localparam int unsigned CW = 11;
    localparam int unsigned HW = 8;
    localparam logic [CW-1:0] W_C    = CW'(SCREEN_W);
    localparam logic [CW-1:0] H_C    = CW'(SCREEN_H);
    localparam logic [CW-1:0] DX_C   = CW'(DX);
    localparam logic [CW-1:0] DY_C   = CW'(DY);
    localparam logic [HW-1:0] HOLD_C = HW'(HOLD_TICKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_SCORED = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    ball_x_q, ball_x_d;
    logic [8:0]    ball_y_q, ball_y_d;
    logic          dir_q, dir_d;          // 1 = moving left
    logic          vdir_up_q, vdir_up_d;
    logic          serve_dir_q, serve_dir_d;
    logic          score_left_q, score_left_d;
    logic          score_right_q, score_right_d;
    logic [HW-1:0] hold_q, hold_d;

    // 11-bit zero-extended geometry so no comparison can wrap
    logic [CW-1:0] bx, by, bw, ww, pw, pl, lpy, rpy;
    logic [CW-1:0] cx, cy, nx, re, face;
    logic          ovl_l, ovl_r, left_miss, right_miss, left_hit, right_hit;
    logic          top_hit, bot_hit, hold_done;
    logic [HW-1:0] hold_inc;

    assign bx  = CW'(ball_x_q);
    assign by  = CW'(ball_y_q);
    assign bw  = CW'(bus.ball_width);
    assign ww  = CW'(bus.wall_width);
    assign pw  = CW'(bus.paddle_width);
    assign pl  = CW'(bus.paddle_length);
    assign lpy = CW'(bus.left_paddle_y);
    assign rpy = CW'(bus.right_paddle_y);

    assign cx   = (W_C - bw) >> 1;
    assign cy   = (H_C - bw) >> 1;
    assign nx   = bx - DX_C;
    assign re   = bx + bw;
    assign face = W_C - pw;

    assign ovl_l = (pl != '0) && (by < lpy + pl) && (by + bw > lpy);
    assign ovl_r = (pl != '0) && (by < rpy + pl) && (by + bw > rpy);

    // A paddle only reflects a ball that crosses its front face on this tick
    assign left_miss  = dir_q && (bx <= DX_C);
    assign right_miss = !dir_q && (re + DX_C >= W_C);
    assign left_hit   = (nx < pw) && (bx >= pw) && ovl_l;
    assign right_hit  = (re + DX_C > face) && (re <= face) && ovl_r;
    assign top_hit    = vdir_up_q && (by < ww + DY_C);
    assign bot_hit    = !vdir_up_q && (by + bw + DY_C > H_C - ww);

    assign hold_inc  = hold_q + HW'(1);
    assign hold_done = (hold_inc == HOLD_C);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ball_x_q      <= 10'(cx);
            ball_y_q      <= 9'(cy);
            dir_q         <= 1'b1;
            vdir_up_q     <= 1'b0;
            serve_dir_q   <= 1'b1;
            score_left_q  <= 1'b0;
            score_right_q <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            dir_q         <= dir_d;
            vdir_up_q     <= vdir_up_d;
            serve_dir_q   <= serve_dir_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            hold_q        <= hold_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.serve) state_d = S_PLAY;
            S_PLAY:   if (bus.tick && (left_miss || right_miss)) state_d = S_SCORED;
            S_SCORED: if (bus.tick && hold_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Ball motion, scoring and hold counting
    always_comb begin
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        dir_d         = dir_q;
        vdir_up_d     = vdir_up_q;
        serve_dir_d   = serve_dir_q;
        score_left_d  = 1'b0;
        score_right_d = 1'b0;
        hold_d        = hold_q;
        unique case (state_q)
            S_IDLE: begin
                ball_x_d  = 10'(cx);
                ball_y_d  = 9'(cy);
                vdir_up_d = 1'b0;
                if (bus.serve) dir_d = serve_dir_q;
            end
            S_PLAY: if (bus.tick) begin
                if (left_miss) begin
                    score_right_d = 1'b1;
                    serve_dir_d   = 1'b1;
                end else if (right_miss) begin
                    score_left_d = 1'b1;
                    serve_dir_d  = 1'b0;
                end else begin
                    if (dir_q) begin
                        if (left_hit) begin
                            ball_x_d = 10'(pw);
                            dir_d    = 1'b0;
                        end else begin
                            ball_x_d = 10'(nx);
                        end
                    end else if (right_hit) begin
                        ball_x_d = 10'(face - bw);
                        dir_d    = 1'b1;
                    end else begin
                        ball_x_d = 10'(bx + DX_C);
                    end
                    if (top_hit) begin
                        ball_y_d  = 9'(ww);
                        vdir_up_d = 1'b0;
                    end else if (bot_hit) begin
                        ball_y_d  = 9'(H_C - ww - bw);
                        vdir_up_d = 1'b1;
                    end else if (vdir_up_q) begin
                        ball_y_d = 9'(by - DY_C);
                    end else begin
                        ball_y_d = 9'(by + DY_C);
                    end
                end
            end
            S_SCORED: if (bus.tick) begin
                if (hold_done) begin
                    hold_d    = '0;
                    ball_x_d  = 10'(cx);
                    ball_y_d  = 9'(cy);
                    vdir_up_d = 1'b0;
                    dir_d     = serve_dir_q;
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: ;
        endcase
    end

    assign bus.ball_x         = ball_x_q;
    assign bus.ball_y         = ball_y_q;
    assign bus.ball_direction = dir_q;
    assign bus.score_left     = score_left_q;
    assign bus.score_right    = score_right_q;
    assign bus.state          = state_q;
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed game scenarios plus randomized games, all
// compared every clock against an integer velocity-based model of the ball.
module tb_ball_motion;
    localparam int W = 640;
    localparam int H = 480;
    localparam int HOLD = 60;
    localparam int P_IDLE = 0, P_PLAY = 1, P_SCORED = 2;

    logic clk = 1'b0;
    logic reset;
    ball_motion_if bif ();

    ball_motion dut (.clk(clk), .reset(reset), .bus(bif.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: position plus signed velocities
    int m_phase, m_x, m_y, m_vx, m_vy, m_serve_vx, m_sl, m_sr, m_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit covers(int y, int bw, int py, int pl);
        return (pl > 0) && (y < py + pl) && (y + bw > py);
    endfunction

    function automatic void model_clk(bit r, bit t, bit s);
        int bw = int'(bif.ball_width);
        int ww = int'(bif.wall_width);
        int pw = int'(bif.paddle_width);
        int pl = int'(bif.paddle_length);
        int nx, ny;
        m_sl = 0;
        m_sr = 0;
        if (r) begin
            m_phase = P_IDLE; m_x = (W - bw) / 2; m_y = (H - bw) / 2;
            m_vx = -4; m_vy = 2; m_serve_vx = -4; m_hold = 0;
            return;
        end
        case (m_phase)
            P_IDLE: begin
                m_x = (W - bw) / 2; m_y = (H - bw) / 2; m_vy = 2;
                if (s) begin m_phase = P_PLAY; m_vx = m_serve_vx; end
            end
            P_PLAY: if (t) begin
                nx = m_x + m_vx;
                if (m_vx < 0 && nx <= 0) begin
                    m_sr = 1; m_serve_vx = -4; m_phase = P_SCORED;
                end else if (m_vx > 0 && nx + bw >= W) begin
                    m_sl = 1; m_serve_vx = 4; m_phase = P_SCORED;
                end else begin
                    if (m_vx < 0 && m_x >= pw && nx < pw &&
                        covers(m_y, bw, int'(bif.left_paddle_y), pl)) begin
                        m_x = pw; m_vx = 4;
                    end else if (m_vx > 0 && m_x + bw <= W - pw && nx + bw > W - pw &&
                               covers(m_y, bw, int'(bif.right_paddle_y), pl)) begin
                        m_x = W - pw - bw; m_vx = -4;
                    end else begin
                        m_x = nx;
                    end
                    ny = m_y + m_vy;
                    if (m_vy < 0 && ny < ww) begin
                        m_y = ww; m_vy = 2;
                    end else if (m_vy > 0 && ny + bw > H - ww) begin
                        m_y = H - ww - bw; m_vy = -2;
                    end else begin
                        m_y = ny;
                    end
                end
            end
            default: if (t) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_hold = 0; m_phase = P_IDLE; m_vy = 2; m_vx = m_serve_vx;
                    m_x = (W - bw) / 2; m_y = (H - bw) / 2;
                end
            end
        endcase
    endfunction

    task automatic compare_all();
        chk("ball_x", 32'(bif.ball_x), m_x);
        chk("ball_y", 32'(bif.ball_y), m_y);
        chk("ball_direction", 32'(bif.ball_direction), (m_vx < 0) ? 1 : 0);
        chk("score_left", 32'(bif.score_left), m_sl);
        chk("score_right", 32'(bif.score_right), m_sr);
        chk("state", 32'(bif.state), m_phase);
    endtask

    task automatic step(input bit r, input bit t, input bit s);
        reset = r; bif.tick = t; bif.serve = s;
        model_clk(r, t, s);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_geom(input int ww, input int bw, input int pw, input int pl,
                            input int lpy, input int rpy);
        bif.wall_width = 6'(ww); bif.ball_width = 6'(bw); bif.paddle_width = 6'(pw);
        bif.paddle_length = 9'(pl); bif.left_paddle_y = 9'(lpy); bif.right_paddle_y = 9'(rpy);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; bif.tick = 1'b0; bif.serve = 1'b0;
        set_geom(8, 6, 10, 480, 0, 0);

        // Reset state
        step(1, 0, 0);
        chk("rst_x", 32'(bif.ball_x), 317);
        chk("rst_y", 32'(bif.ball_y), 237);
        chk("rst_state", 32'(bif.state), 0);
        chk("rst_dir", 32'(bif.ball_direction), 1);
        chk("rst_scores", 32'({bif.score_left, bif.score_right}), 0);

        // Left paddle bounce and bottom wall bounce
        step(0, 0, 1);
        for (int i = 1; i <= 116; i++) begin
            step(0, 1, 0);
            if (i == 76) chk("pre_bounce_x", 32'(bif.ball_x), 13);
            if (i == 77) begin
                chk("bounce_x", 32'(bif.ball_x), 10);
                chk("bounce_dir", 32'(bif.ball_direction), 0);
            end
            if (i == 114) chk("pre_wall_y", 32'(bif.ball_y), 465);
            if (i == 115) chk("wall_y", 32'(bif.ball_y), 466);
            if (i == 116) chk("after_wall_y", 32'(bif.ball_y), 464);
        end

        // No tick: frozen; serve ignored in PLAY
        for (int i = 0; i < 100; i++) step(0, 0, (i % 10) == 3);
        chk("idle_tick_x", 32'(bif.ball_x), 166);
        chk("idle_tick_y", 32'(bif.ball_y), 464);
        chk("idle_tick_state", 32'(bif.state), 1);

        // Left miss, score pulse, hold, re-centre
        step(1, 0, 0);
        set_geom(8, 6, 10, 0, 0, 0);
        step(0, 0, 1);
        for (int i = 1; i <= 80; i++) begin
            step(0, 1, 0);
            if (i == 79) chk("pre_miss_x", 32'(bif.ball_x), 1);
        end
        chk("miss_score_right", 32'(bif.score_right), 1);
        chk("miss_state", 32'(bif.state), 2);
        chk("miss_frozen_x", 32'(bif.ball_x), 1);
        chk("miss_frozen_y", 32'(bif.ball_y), 395);
        step(0, 0, 1);
        chk("pulse_one_clk", 32'(bif.score_right), 0);
        for (int i = 1; i <= 60; i++) begin
            step(0, 1, 0);
            if (i == 59) chk("hold59_state", 32'(bif.state), 2);
        end
        chk("recentre_state", 32'(bif.state), 0);
        chk("recentre_x", 32'(bif.ball_x), 317);
        chk("recentre_y", 32'(bif.ball_y), 237);
        chk("recentre_dir", 32'(bif.ball_direction), 1);

        // Reset mid-PLAY
        step(1, 0, 0);
        set_geom(8, 6, 10, 480, 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < 29; i++) step(0, 1, 0);
        chk("mid_play_x", 32'(bif.ball_x), 201);
        step(1, 1, 0);
        chk("mid_rst_x", 32'(bif.ball_x), 317);
        chk("mid_rst_state", 32'(bif.state), 0);

        // Reset mid-SCORED discards the hold count
        set_geom(8, 6, 10, 0, 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < 80; i++) step(0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < 80; i++) step(0, 1, 0);
        for (int i = 1; i <= 60; i++) begin
            step(0, 1, 0);
            if (i == 59) chk("fresh_hold59", 32'(bif.state), 2);
        end
        chk("fresh_hold60", 32'(bif.state), 0);

        // Randomized games with random geometry chosen while idle
        for (int g = 0; g < 16; g++) begin
            int pl_sel = int'($urandom_range(0, 2));
            set_geom(int'($urandom_range(0, 63)), int'($urandom_range(1, 63)),
                     int'($urandom_range(0, 63)),
                     (pl_sel == 0) ? 0 : (pl_sel == 1) ? 480 : int'($urandom_range(1, 300)),
                     int'($urandom_range(0, 479)), int'($urandom_range(0, 479)));
            step(0, 1'($urandom_range(0, 1)), 0);
            step(0, 1'($urandom_range(0, 1)), 1);
            cyc = 0;
            while (m_phase != P_IDLE && cyc < 2500) begin
                step(0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
                cyc++;
            end
            if (m_phase != P_IDLE) step(1, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Upstream stage of both paddle blocks. Owns the ball: position, horizontal and vertical direction, and the serve/score sequence.
- Bounces the ball off the top and bottom walls and off the front faces of both paddles. Detects misses and emits one-cycle score pulses.
- Outputs ball_x, ball_y and ball_direction, which drive the paddle AI and the renderer.

Parameters:
- SCREEN_W, 640, playfield width in pixels.
- SCREEN_H, 480, playfield height in pixels.
- DX, 4, horizontal step per tick.
- DY, 2, vertical step per tick.
- HOLD_TICKS, 60, number of ticks spent in SCORED before re-centering; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  frame-update strobe; motion happens only on clk edges where tick=1.
- serve  in  1  launches the ball from IDLE; ignored in every other state.
- wall_width  in  6  top/bottom wall thickness.
- ball_width  in  6  ball side length (the ball is square).
- paddle_width  in  6  paddle thickness; left face at x=0, right face at SCREEN_W-paddle_width.
- paddle_length  in  9  paddle height.
- left_paddle_y  in  9  upper edge of the left paddle.
- right_paddle_y  in  9  upper edge of the right paddle.
- ball_x  out  10  upper-left x of the ball.
- ball_y  out  9  upper-left y of the ball.
- ball_direction  out  1  1 = moving left (toward side 1), 0 = moving right.
- score_left  out  1  one-clk pulse: left player scored (ball exited right).
- score_right  out  1  one-clk pulse: right player scored (ball exited left).
- state  out  2  0 IDLE, 1 PLAY, 2 SCORED.

Behaviour:
- All outputs registered. Geometry inputs are sampled on every tick; they must be stable during PLAY.
- Reset (synchronous, wins over everything, including mid-PLAY and mid-SCORED):
  - state=IDLE, ball_x=(SCREEN_W-ball_width)>>1, ball_y=(SCREEN_H-ball_width)>>1.
  - ball_direction=1, vdir=down, serve_dir=1, scores=0, hold counter=0.
- IDLE:
  - Ball stays centred and is recomputed every clk from ball_width.
  - serve=1 -> PLAY on the next edge, ball_direction<=serve_dir. Motion starts on the first tick after entry.
- PLAY, on tick, horizontal move, moving left:
  - If ball_x<=DX: miss. score_right<=1, serve_dir<=1, -> SCORED, position frozen.
  - Else nx=ball_x-DX. If nx<paddle_width AND ball_x>=paddle_width AND overlap(left_paddle_y): ball_x<=paddle_width, ball_direction<=0.
  - Else ball_x<=nx.
- PLAY, on tick, horizontal move, moving right (r=ball_x+ball_width, face=SCREEN_W-paddle_width):
  - If r+DX>=SCREEN_W: miss. score_left<=1, serve_dir<=0, -> SCORED.
  - Else if r+DX>face AND r<=face AND overlap(right_paddle_y): ball_x<=face-ball_width, ball_direction<=1.
  - Else ball_x<=ball_x+DX.
- Overlap rule: overlap(p) = ball_y<p+paddle_length AND ball_y+ball_width>p, using the pre-update ball_y. paddle_length=0 never overlaps.
- Once the ball is past a paddle's front face it never bounces; it travels on until the miss.
- PLAY, on tick, vertical move, evaluated in the same tick as and independently of the horizontal move:
  - Moving up with ball_y<wall_width+DY: ball_y<=wall_width, vdir<=down.
  - Moving down with ball_y+ball_width+DY>SCREEN_H-wall_width: ball_y<=SCREEN_H-wall_width-ball_width, vdir<=up.
  - Otherwise ball_y moves by ±DY.
  - On a miss tick ball_y is not updated.
- Arithmetic: all comparisons are done at 11 bits, zero-extended, with no wrap. A paddle bounce and a wall bounce on the same tick both apply.
- SCORED:
  - Score pulses are high for exactly one clk, on the PLAY->SCORED edge.
  - The hold counter increments on each tick. When it reaches HOLD_TICKS: -> IDLE, counter<=0, ball re-centred, vdir<=down, ball_direction<=serve_dir.
  - Serve always goes toward the player who conceded.
  - serve is ignored in PLAY and SCORED.

Test Plan:
1. Reset, ball_width=6 -> ball_x=317, ball_y=237, state=0, ball_direction=1, no score pulses.
2. wall_width=8, paddle_width=10, paddle_length=480, both paddle_y=0; serve, then 77 ticks -> after tick 76 ball_x=13; after tick 77 ball_x=10, ball_direction=0.
3. Same setup as scenario 2 -> after tick 114 ball_y=465 moving down; tick 115 -> ball_y=466, vdir=up.
4. paddle_length=0; serve, then 80 ticks -> ball_x=1 after tick 79; tick 80 -> score_right high for exactly one clk, state=2, ball frozen; after 60 further ticks -> state=0, ball at (317,237), ball_direction=1.
5. tick held 0 for 100 clks in PLAY -> no position change; serve pulsed during PLAY -> no effect.
6. Reset asserted for one clk mid-PLAY at ball_x=201 -> next clk all reset values; a pending SCORED hold count is discarded.
